// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding and default sizing for the sequential divider
package seq_divider_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;
  localparam logic [DEF_WIDTH-1:0] DEF_INT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ITER = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division step on a WIDTH+1 bit partial remainder
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  always_comb begin
    q_bit    = {rem, din} >= {2'b00, divisor};
    rem_next = q_bit ? {rem[WIDTH-1:0], din} - {1'b0, divisor} : {rem[WIDTH-1:0], din};
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multicycle signed restoring divider, one quotient bit per clock
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operand_a,
  input  logic [WIDTH-1:0] data_operand_b,
  output logic [WIDTH-1:0] data_quotient,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_result_rdy,
  output logic             busy
);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem, rem_next;
  logic [WIDTH-1:0] dvd, dvs, abs_a, abs_b;
  logic             sign_q, sign_r, q_bit;
  always_comb begin
    abs_a = data_operand_a[WIDTH-1] ? -data_operand_a : data_operand_a;
    abs_b = data_operand_b[WIDTH-1] ? -data_operand_b : data_operand_b;
  end
  // dvd shifts dividend bits out the top while quotient bits fill in at the bottom
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem),
    .din(dvd[WIDTH-1]),
    .divisor(dvs),
    .rem_next(rem_next),
    .q_bit(q_bit)
  );
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= DIV_IDLE;
      cnt             <= '0;
      rem             <= '0;
      dvd             <= '0;
      dvs             <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      data_quotient   <= '0;
      data_remainder  <= '0;
      data_exception  <= 1'b0;
      data_result_rdy <= 1'b0;
      busy            <= 1'b0;
    end else begin
      data_result_rdy <= 1'b0;
      case (state)
        DIV_IDLE: if (ctrl_div) begin
          dvd    <= abs_a;
          dvs    <= abs_b;
          sign_q <= data_operand_a[WIDTH-1] ^ data_operand_b[WIDTH-1];
          sign_r <= data_operand_a[WIDTH-1];
          cnt    <= '0;
          rem    <= '0;
          busy   <= 1'b1;
          if (data_operand_b == '0) begin
            state           <= DIV_DONE;
            data_quotient   <= '0;
            data_remainder  <= data_operand_a;
            data_exception  <= 1'b1;
            data_result_rdy <= 1'b1;
          end else if (data_operand_a == INT_MIN && data_operand_b == '1) begin
            state           <= DIV_DONE;
            data_quotient   <= INT_MIN;
            data_remainder  <= '0;
            data_exception  <= 1'b1;
            data_result_rdy <= 1'b1;
          end else
            state <= DIV_ITER;
        end
        DIV_ITER: begin
          rem   <= rem_next;
          dvd   <= {dvd[WIDTH-2:0], q_bit};
          cnt   <= cnt + 1'b1;
          state <= cnt == CNT_W'(WIDTH - 1) ? DIV_FIX : DIV_ITER;
        end
        DIV_FIX: begin
          data_quotient   <= sign_q ? -dvd : dvd;
          data_remainder  <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          data_exception  <= 1'b0;
          data_result_rdy <= 1'b1;
          state           <= DIV_DONE;
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized scoreboard bench for seq_divider
module tb_seq_divider;
  import seq_divider_pkg::*;
  localparam int W = DEF_WIDTH;
  localparam int LAT = W + 2;
  localparam logic [W-1:0] IMIN = DEF_INT_MIN;
  logic clock = 1'b0, reset_n = 1'b0, ctrl_div = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] dq, dr;
  logic de, rdy, busy;
  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic e;
    int lat;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [W-1:0] prev_q = '0, prev_r = '0;
  logic prev_e = 1'b0;

  seq_divider dut (
    .clock(clock), .reset_n(reset_n), .ctrl_div(ctrl_div),
    .data_operand_a(a), .data_operand_b(b),
    .data_quotient(dq), .data_remainder(dr), .data_exception(de),
    .data_result_rdy(rdy), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t m;
    logic signed [W-1:0] sx, sy;
    sx = x;
    sy = y;
    m.a = x;
    m.b = y;
    if (y == '0) begin
      m.q = '0; m.r = x; m.e = 1'b1; m.lat = 1;
    end else if (x == IMIN && y == '1) begin
      m.q = IMIN; m.r = '0; m.e = 1'b1; m.lat = 1;
    end else begin
      m.q = sx / sy; m.r = sx % sy; m.e = 1'b0; m.lat = LAT;
    end
    return m;
  endfunction

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_rdy(output int lat, output logic seen);
    lat = 1;
    while (!rdy && lat < LAT + 20) begin
      @(negedge clock);
      lat++;
    end
    seen = rdy;
  endtask

  task automatic finish_op(input string tag, input int lat, input logic seen);
    exp_t m;
    m = sb.pop_front();
    check({tag, " rdy seen"}, W'(seen), 1);
    check({tag, " latency"}, W'(lat), W'(m.lat));
    check({tag, " quotient"}, dq, m.q);
    check({tag, " remainder"}, dr, m.r);
    check({tag, " exception"}, W'(de), W'(m.e));
    if (!m.e) begin
      check({tag, " q*b+r"}, dq * m.b + dr, m.a);
      check({tag, " |r|<|b|"}, W'(mag(dr) < mag(m.b)), 1);
    end
    prev_q = m.q;
    prev_r = m.r;
    prev_e = m.e;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    logic seen;
    @(negedge clock);
    ctrl_div = 1'b1; a = x; b = y;
    sb.push_back(model(x, y));
    @(negedge clock);
    ctrl_div = 1'b0;
    check({tag, " busy"}, W'(busy), 1);
    if (sb[0].lat > 1) begin
      check({tag, " hold q"}, dq, prev_q);
      check({tag, " hold r"}, dr, prev_r);
      check({tag, " hold e"}, W'(de), W'(prev_e));
    end
    wait_rdy(lat, seen);
    finish_op(tag, lat, seen);
    @(negedge clock);
    check({tag, " rdy drop"}, W'(rdy), 0);
    check({tag, " busy drop"}, W'(busy), 0);
    check({tag, " post hold q"}, dq, prev_q);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clock);
      if (rdy) seen = 1'b1;
    end
    check(tag, W'(seen), 0);
  endtask

  initial begin
    int lat;
    logic seen;
    logic [W-1:0] x, y;
    repeat (2) @(negedge clock);
    check("reset q", dq, 0);
    check("reset r", dr, 0);
    check("reset e", W'(de), 0);
    check("reset rdy", W'(rdy), 0);
    check("reset busy", W'(busy), 0);
    reset_n = 1'b1;

    run_op("7/2", 7, 2);
    run_op("100/-7", 100, -32'sd7);
    run_op("-100/7", -32'sd100, 7);
    run_op("5/0", 5, 0);
    run_op("min/-1", IMIN, '1);
    run_op("min/2", IMIN, 2);

    // operands and ctrl_div keep changing during ITER; only the first accept counts
    @(negedge clock);
    ctrl_div = 1'b1; a = 1000; b = 10;
    sb.push_back(model(1000, 10));
    @(negedge clock);
    a = 7; b = 5;
    wait_rdy(lat, seen);
    ctrl_div = 1'b0;
    finish_op("held", lat, seen);
    @(negedge clock);
    check("held busy drop", W'(busy), 0);
    check("held rdy drop", W'(rdy), 0);
    expect_quiet("held no second rdy", 40);

    @(negedge clock);
    ctrl_div = 1'b1; a = 32'h7FFF_FFFF; b = 3;
    @(negedge clock);
    ctrl_div = 1'b0;
    repeat (8) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("abort q", dq, 0);
    check("abort r", dr, 0);
    check("abort e", W'(de), 0);
    check("abort busy", W'(busy), 0);
    check("abort rdy", W'(rdy), 0);
    prev_q = '0; prev_r = '0; prev_e = 1'b0;
    expect_quiet("abort no rdy", 40);
    run_op("9/3", 9, 3);

    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = '0;
        1: begin x = IMIN; y = '1; end
        2: x = IMIN;
        3: y = $urandom_range(1, 16);
        4: y = -W'($urandom_range(1, 16));
        5: x = $urandom_range(0, 100) - 50;
        default: ;
      endcase
      run_op("rand", x, y);
    end

    check("scoreboard empty", W'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
